// File: rtl/switch_pkg.sv
// Shared constants and the rotating-priority pick used by the 5x5 switch.
// Port order L,N,E,S,W doubles as the request code and the search order.
package switch_pkg;
  localparam int L = 0;
  localparam int N = 1;
  localparam int E = 2;
  localparam int S = 3;
  localparam int W = 4;
  localparam int NUM_PORTS = 5;
  localparam int DEF_DATA_W = 8;
  localparam logic [2:0] REQ_IDLE = 3'b111;

  // One-hot grant of the first requester found starting at 'start'.
  function automatic logic [NUM_PORTS-1:0] pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [2:0] start
  );
    logic [NUM_PORTS-1:0] g;
    logic [2:0] idx;
    g = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = 3'((int'(start) + k) % NUM_PORTS);
      if (req[idx]) begin
        g = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/switch_arbiter.sv
// Per-output arbiter: fixed L>N>E>S>W, or round-robin when
// SWITCH_RR_ARB_EN is defined.
module switch_arbiter
  import switch_pkg::*;
(
`ifdef SWITCH_RR_ARB_EN
  input  logic                 clk,
  input  logic                 rst,
`endif
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef SWITCH_RR_ARB_EN
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;

  assign grant = pick(req, ptr);

  // Next search starts just past the port granted this cycle.
  always_comb begin
    ptr_nxt = ptr;
    unique case (1'b1)
      grant[L]: ptr_nxt = 3'(N);
      grant[N]: ptr_nxt = 3'(E);
      grant[E]: ptr_nxt = 3'(S);
      grant[S]: ptr_nxt = 3'(W);
      grant[W]: ptr_nxt = 3'(L);
      default:  ptr_nxt = ptr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= 3'(L);
    else      ptr <= ptr_nxt;
  end
`else
  assign grant = pick(req, 3'(L));
`endif

endmodule

// File: rtl/switch.sv
// 5x5 registered crossbar: request decode, per-output arbiters,
// output muxes and output registers. Optional macro: SWITCH_RR_ARB_EN.
module switch
  import switch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] In_L,
  input  logic [DATA_W-1:0] In_N,
  input  logic [DATA_W-1:0] In_E,
  input  logic [DATA_W-1:0] In_W,
  input  logic [DATA_W-1:0] In_S,
  input  logic [2:0]        request_L,
  input  logic [2:0]        request_N,
  input  logic [2:0]        request_E,
  input  logic [2:0]        request_S,
  input  logic [2:0]        request_W,
  output logic [DATA_W-1:0] Out_L,
  output logic [DATA_W-1:0] Out_N,
  output logic [DATA_W-1:0] Out_E,
  output logic [DATA_W-1:0] Out_W,
  output logic [DATA_W-1:0] Out_S
);

  logic [DATA_W-1:0]    din   [NUM_PORTS];
  logic [2:0]           rq    [NUM_PORTS];
  logic [NUM_PORTS-1:0] want  [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant [NUM_PORTS];
  logic [DATA_W-1:0]    nxt   [NUM_PORTS];
  logic [DATA_W-1:0]    q     [NUM_PORTS];

  assign din[L] = In_L;
  assign din[N] = In_N;
  assign din[E] = In_E;
  assign din[S] = In_S;
  assign din[W] = In_W;

  assign rq[L] = request_L;
  assign rq[N] = request_N;
  assign rq[E] = request_E;
  assign rq[S] = request_S;
  assign rq[W] = request_W;

  // Codes 5..7 match no output, so idle inputs request nothing.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      want[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        want[o][i] = (rq[i] == 3'(o));
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    switch_arbiter u_arb (
`ifdef SWITCH_RR_ARB_EN
      .clk   (clk),
      .rst   (rst),
`endif
      .req   (want[g]),
      .grant (grant[g])
    );
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      nxt[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        if (grant[o][i]) nxt[o] = nxt[o] | din[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) q[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) q[o] <= nxt[o];
    end
  end

  assign Out_L = q[L];
  assign Out_N = q[N];
  assign Out_E = q[E];
  assign Out_S = q[S];
  assign Out_W = q[W];

endmodule

// File: tb/tb_switch.sv
// Self-checking bench for switch: directed scenarios plus random
// traffic against a queue-free per-output arbitration model.
module tb_switch;
  import switch_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] in_d [NUM_PORTS];
  logic [2:0] rq   [NUM_PORTS];
  logic [7:0] out  [NUM_PORTS];
  logic [7:0] exp_o [NUM_PORTS];
  int         ptr  [NUM_PORTS];
  int         checks;
  int         failures;

  switch #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_L      (in_d[L]),
    .In_N      (in_d[N]),
    .In_E      (in_d[E]),
    .In_W      (in_d[W]),
    .In_S      (in_d[S]),
    .request_L (rq[L]),
    .request_N (rq[N]),
    .request_E (rq[E]),
    .request_S (rq[S]),
    .request_W (rq[W]),
    .Out_L     (out[L]),
    .Out_N     (out[N]),
    .Out_E     (out[E]),
    .Out_W     (out[W]),
    .Out_S     (out[S])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each output scans inputs from its start port; fixed
  // priority always starts at L, round-robin starts after last winner.
  task automatic model_step();
    for (int o = 0; o < NUM_PORTS; o++) begin
      int won;
      won = -1;
      for (int k = 0; k < NUM_PORTS; k++) begin
        int p;
        p = (ptr[o] + k) % NUM_PORTS;
        if (won < 0 && int'(rq[p]) == o) won = p;
      end
      exp_o[o] = (won < 0) ? 8'h00 : in_d[won];
`ifdef SWITCH_RR_ARB_EN
      if (won >= 0) ptr[o] = (won + 1) % NUM_PORTS;
`endif
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NUM_PORTS; o++) begin
      ptr[o] = 0;
      exp_o[o] = 8'h00;
    end
  endtask

  task automatic all_idle();
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_d[i] = 8'h00;
      rq[i] = REQ_IDLE;
    end
  endtask

  task automatic step_check(input string name);
    model_step();
    @(posedge clk);
    #1;
    for (int o = 0; o < NUM_PORTS; o++) begin
      checks++;
      if (out[o] !== exp_o[o]) begin
        failures++;
        $display("FAIL %s out[%0d] got=%h exp=%h", name, o, out[o], exp_o[o]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        in_d[i] = 8'($urandom);
        rq[i] = 3'($urandom_range(0, 7));
      end
      #10;
      for (int o = 0; o < NUM_PORTS; o++) begin
        checks++;
        if (out[o] !== 8'h00) begin
          failures++;
          $display("FAIL reset_hold out[%0d] got=%h exp=00", o, out[o]);
        end
      end
    end
    all_idle();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) step_check("reset_idle");
  endtask

  task automatic test_loopback();
    all_idle();
    in_d[L] = 8'h02;
    rq[L] = 3'(L);
    step_check("loopback");
    checks++;
    if (out[L] !== 8'h02) begin
      failures++;
      $display("FAIL loopback_L got=%h exp=02", out[L]);
    end
  endtask

  task automatic test_turn();
    all_idle();
    in_d[N] = 8'h03;
    rq[N] = 3'(E);
    step_check("turn");
    checks++;
    if (out[E] !== 8'h03 || out[L] !== 8'h00) begin
      failures++;
      $display("FAIL turn_NE got E=%h L=%h exp E=03 L=00", out[E], out[L]);
    end
  endtask

  task automatic test_concurrent();
    all_idle();
    in_d[L] = 8'hA1; rq[L] = 3'(N);
    in_d[E] = 8'hB2; rq[E] = 3'(W);
    in_d[S] = 8'hC3; rq[S] = 3'(S);
    step_check("concurrent");
    checks++;
    if (out[N] !== 8'hA1 || out[W] !== 8'hB2 || out[S] !== 8'hC3) begin
      failures++;
      $display("FAIL concurrent got N=%h W=%h S=%h exp A1 B2 C3",
               out[N], out[W], out[S]);
    end
  endtask

  task automatic test_contention();
    all_idle();
    in_d[L] = 8'h11; rq[L] = 3'(E);
    in_d[W] = 8'h55; rq[W] = 3'(E);
    for (int c = 0; c < 4; c++) step_check("contention");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        in_d[i] = 8'($urandom);
        rq[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7))
                                            : 3'($urandom_range(0, 4));
      end
      step_check("random");
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] seq [3];
`ifdef SWITCH_RR_ARB_EN
    seq[0] = 8'h11; seq[1] = 8'h55; seq[2] = 8'h11;
`else
    seq[0] = 8'h11; seq[1] = 8'h11; seq[2] = 8'h11;
`endif
    all_idle();
    in_d[L] = 8'h11; rq[L] = 3'(E);
    in_d[W] = 8'h55; rq[W] = 3'(E);
    in_d[N] = 8'h77; rq[N] = 3'(N);
    step_check("pre_reset");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    for (int o = 0; o < NUM_PORTS; o++) begin
      checks++;
      if (out[o] !== 8'h00) begin
        failures++;
        $display("FAIL async_reset out[%0d] got=%h exp=00", o, out[o]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step_check("post_reset");
      checks++;
      if (out[E] !== seq[c]) begin
        failures++;
        $display("FAIL rr_restart cycle=%0d got=%h exp=%h", c, out[E], seq[c]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    all_idle();
    test_reset();
    test_loopback();
    test_turn();
    test_concurrent();
    test_contention();
    test_random();
    test_mid_reset();
    all_idle();
    step_check("final_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
